// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction prefetcher: issues word fetches into a small FIFO and flushes it on a branch redirect.
// Defining FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    REDIRECT  = 2'd1,
    HALT_FULL = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          pend_q, pend_d;
  logic          squash_q, squash_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic          push, pop, wr_en;

  logic [31:0]   inst_mem [QUEUE_DEPTH];
  logic [31:0]   pc_mem   [QUEUE_DEPTH];

  // Redirect targets are forced word-aligned, so the low bits are never used.
  logic [1:0]    unused_target_bits;
  assign unused_target_bits = branch_target[1:0];

  assign inst_valid   = (count_q != '0);
  assign inst_out     = inst_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign pc_out       = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;
  assign pc_plus4_out = pc_out + 32'd4;
  assign imem_addr    = fetch_pc_q;

  always_comb begin
    // A response that was squashed by a redirect no longer reserves a queue slot.
    level_q    = count_q + CW'(pend_q & ~squash_q);
    imem_req   = reset & (state_q == RUN) & (level_q < DEPTH_C);
    push       = imem_valid & pend_q & ~squash_q;
    pop        = inst_valid & ~stall;
    wr_en      = push & ~branch_taken;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pend_d     = imem_req;
    squash_d   = 1'b0;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = '0;

    if (imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_addr_d = fetch_pc_q;
    end

    if (branch_taken) begin
      fetch_pc_d = {branch_target[31:2], 2'b00};
      squash_d   = imem_req;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      state_d    = REDIRECT;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      level_d = count_d + CW'(pend_d);
      if (state_q == REDIRECT) begin
        state_d = RUN;
      end else if (level_d >= DEPTH_C) begin
        state_d = HALT_FULL;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      pend_q     <= 1'b0;
      squash_q   <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pend_q     <= pend_d;
      squash_q   <= squash_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset: entries are only visible when count_q covers them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= req_addr_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (imem_req && (fetch_count_q != 32'hFFFF_FFFF)) fetch_count_d = fetch_count_q + 32'd1;
    if (stall && inst_valid && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out, pc_out, pc_plus4_out;

  logic        resp_valid, inj_valid;
  logic [31:0] resp_data, inj_data, data_key;

  logic        req2, valid2, iv2;
  logic [31:0] addr2, rdata2, inst2, pc2, p42;

  int n_total = 0;
  int n_pass  = 0;

  fetch_prefetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_out(inst_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out)
  );

  fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_valid(valid2), .imem_rdata(rdata2), .inst_valid(iv2),
    .inst_out(inst2), .pc_out(pc2), .pc_plus4_out(p42)
  );

  // Memory: answers exactly one cycle after an accepted request.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      valid2     <= 1'b0;
      rdata2     <= 32'h0;
    end else begin
      resp_valid <= imem_req;
      resp_data  <= imem_addr ^ data_key;
      valid2     <= req2;
      rdata2     <= addr2;
    end
  end
  assign imem_valid = resp_valid | inj_valid;
  assign imem_rdata = inj_valid ? inj_data : resp_data;

  // Reference model: a plain queue of {pc, inst} plus the fetch pointer.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc, m_pend_addr;
  bit          m_pend, m_redir;

  function automatic bit m_req();
    return !m_redir && ((m_q.size() + (m_pend ? 1 : 0)) < DEPTH);
  endfunction

  task automatic model_reset(input logic [31:0] pc);
    m_q.delete();
    m_pc    = pc;
    m_pend  = 1'b0;
    m_redir = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit b, input logic [31:0] t);
    bit   req, do_pop;
    ent_t e;
    req    = m_req();
    do_pop = (m_q.size() != 0) && !s;
    if (b) begin
      m_q.delete();
      m_pc    = {t[31:2], 2'b00};
      m_pend  = 1'b0;
      m_redir = 1'b1;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (m_pend) begin
        e.pc   = m_pend_addr;
        e.inst = m_pend_addr ^ data_key;
        m_q.push_back(e);
      end
      m_pend      = req;
      m_pend_addr = m_pc;
      if (req) m_pc = m_pc + 32'd4;
      m_redir = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic compare_model();
    chk("m_imem_req", {31'h0, imem_req}, {31'h0, m_req()});
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_inst_valid", {31'h0, inst_valid}, {31'h0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("m_pc_out", pc_out, m_q[0].pc);
      chk("m_inst_out", inst_out, m_q[0].inst);
      chk("m_pc_plus4", pc_plus4_out, m_q[0].pc + 32'd4);
    end else begin
      chk("m_pc_out_empty", pc_out, 32'h0);
      chk("m_inst_out_empty", inst_out, 32'h0);
      chk("m_pc_plus4_empty", pc_plus4_out, 32'd4);
    end
  endtask

  task automatic tick(input bit s, input bit b, input logic [31:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    compare_model();
    @(posedge clk);
    model_edge(s, b, t);
    #1;
    inj_valid = 1'b0;
  endtask

  task automatic do_reset(input bit inject, input logic [31:0] key);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pc_plus4", pc_plus4_out, 32'd4);
    data_key = key;
    model_reset(32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    if (inject) begin
      inj_valid = 1'b1;
      inj_data  = 32'hBAD0_BAD0;
    end
    #1;
  endtask

  typedef struct {
    bit          restart;
    bit          stall;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    bit          chk2;
    logic [31:0] exp_pc2;
    logic [31:0] exp_p42;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int n_req;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    inj_valid = 1'b0; inj_data = 32'h0; data_key = 32'h0;
    model_reset(32'h0);

    // Straight-line fetch from reset, with the wrap instance checked alongside.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h8, 1'b1, 32'h0000_0000, 32'h0000_0004};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'hC, 1'b1, 32'h0000_0004, 32'h0000_0008};
    // Stall held 10 cycles, then drained back-to-back.
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    for (int i = 10; i < 16; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0};

    @(posedge clk);
    #1;
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].restart) do_reset(1'b0, 32'h0);
      chk($sformatf("v%0d_imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
      chk($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_inst_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].exp_pc);
      chk($sformatf("v%0d_inst_out", i), inst_out, vecs[i].exp_pc);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4_out, vecs[i].exp_pc + 32'd4);
      if (vecs[i].chk2) begin
        chk($sformatf("v%0d_wrap_valid", i), {31'h0, iv2}, 32'h1);
        chk($sformatf("v%0d_wrap_pc", i), pc2, vecs[i].exp_pc2);
        chk($sformatf("v%0d_wrap_inst", i), inst2, vecs[i].exp_pc2);
        chk($sformatf("v%0d_wrap_pc_plus4", i), p42, vecs[i].exp_p42);
      end
      if (i >= 6 && i <= 15 && imem_req) n_req++;
      if (i == 15) chk("stall_req_count", n_req, 32'd4);
      tick(vecs[i].stall, 1'b0, 32'h0);
    end

    // Redirect while full with a response in flight.
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);
    chk("full_no_req", {31'h0, imem_req}, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_0103);
    chk("br_flush_valid", {31'h0, inst_valid}, 32'h0);
    chk("br_redirect_req", {31'h0, imem_req}, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("br_first_req", {31'h0, imem_req}, 32'h1);
    chk("br_first_addr", imem_addr, 32'h100);
    tick(1'b0, 1'b0, 32'h0);
    chk("br_inflight_dropped", {31'h0, inst_valid}, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("br_pc_out", pc_out, 32'h100);
    chk("br_inst_out", inst_out, 32'h100);

    // Redirect and stall in the same cycle.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);
    chk("bs_has_head", {31'h0, inst_valid}, 32'h1);
    tick(1'b1, 1'b1, 32'h0000_0200);
    chk("bs_head_dropped", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    chk("bs_pc_out", pc_out, 32'h200);

    // Asynchronous reset with three entries held, plus a stray response right after release.
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);
    chk("held_valid", {31'h0, inst_valid}, 32'h1);
    chk("held_pc", pc_out, 32'h0);
    do_reset(1'b1, 32'h5A5A_0000);
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("rel_stray_ignored", {31'h0, inst_valid}, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("rel_pc_out", pc_out, 32'h0);
    chk("rel_inst_out", inst_out, 32'h5A5A_0000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      bit          s, b;
      logic [31:0] t;
      s = ($urandom_range(0, 99) < 40);
      b = ($urandom_range(0, 99) < 4);
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      tick(s, b, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
